pixel_shuffle_2x: RTL and testbench
===================================

Name: pixel_shuffle_2x

Overview:
Downstream stage of the CNN accelerator's last layer. It consumes the 32-bit out_pixel stream, in which each word holds 4 sub-pixel bytes of one low-res position, and performs depth-to-space (pixel shuffle, factor 2). It emits an 8-bit raster stream of the 2W x 2H super-resolution image, with a valid/ready handshake, toward the display/DMA writer.

Parameters:
MAX_WIDTH, 128, maximum low-res width; sets line-buffer depth.
W_SIZE, 12, width of the cfg_width / cfg_height fields.
W_ADDR_LB, $clog2(MAX_WIDTH), line-buffer address width.

Ports:
HCLK  in  1  clock; all logic on the rising edge.
HRESET  in  1  synchronous, active-high reset.
start  in  1  1-cycle pulse; latches cfg and begins a frame (honoured only in IDLE).
cfg_width  in  W_SIZE  low-res width W.
cfg_height  in  W_SIZE  low-res height H.
in_pixel  in  32  [7:0]=(2y,2x), [15:8]=(2y,2x+1), [23:16]=(2y+1,2x), [31:24]=(2y+1,2x+1).
in_valid  in  1  input word valid.
in_ready  out  1  input handshake accept.
out_pixel  out  8  high-res pixel.
out_valid  out  1  output valid; held with stable data until out_ready.
out_ready  in  1  downstream accept.
out_eol  out  1  qualifies the last pixel of a high-res row.
out_eof  out  1  qualifies the last pixel of the frame.
busy  out  1  high from accepted start until frame_done.
frame_done  out  1  1-cycle pulse after the final output handshake.
cfg_err  out  1  1-cycle pulse when start is rejected.

Behaviour:
- Reset: state=IDLE. in_ready, out_valid, out_eol, out_eof, busy, frame_done, cfg_err = 0. out_pixel = 0. Counters = 0. Line-buffer contents are don't-care.
- Reset mid-frame: abort immediately, return to IDLE, discard the partial frame; no frame_done.
- IDLE:
  - start with W=0 or H=0: frame_done next cycle, no output.
  - start with W>MAX_WIDTH: cfg_err next cycle, stay IDLE.
  - Otherwise: latch W and H, busy=1, go to TOP.
- start while busy is ignored.
- TOP (high-res row 2y):
  - in_ready=1 when the output register is empty or being drained and the byte1 emission is done.
  - On an input handshake: emit byte0, then byte1 on the following output slot. Write {byte3,byte2} to line buffer address x.
  - Throughput is 1 word per 2 cycles with out_ready held high.
  - After byte1 of x=W-1 (out_eol=1): go to BOT.
- BOT (high-res row 2y+1):
  - in_ready=0.
  - Read line buffer x=0..W-1 and emit byte2, byte3 per entry at 1 pixel/cycle under out_ready. The synchronous read is prefetched so there are no bubbles.
  - byte3 of x=W-1 has out_eol=1. If y=H-1 it also has out_eof=1, then go to DONE; else y++, go to TOP.
- DONE: frame_done=1 for one cycle, busy=0, go to IDLE.
- Latency: input handshake at cycle t gives out_valid with byte0 at t+1.
- Output register:
  - While out_valid=1 and out_ready=0, out_pixel/eol/eof are frozen.
  - out_valid falls only after a handshake with nothing pending.
  - out_eol and out_eof are 0 whenever out_valid=0.
- Counters:
  - x and y are W_SIZE wide; sub-pixel phase is 1 bit.
  - The total output count is 4*W*H pixels.
- Simultaneous events: start in the DONE cycle is ignored. A handshake and a new pixel load in the same cycle are legal and give no bubble.

Decomposition:
- Shared package: state enum (IDLE, TOP, BOT, DONE), byte-lane index constants (TL=0, TR=1, BL=2, BR=3), MAX_WIDTH default.
- One sub-module: pix_line_buf. 16-bit x MAX_WIDTH single-port sync RAM, 1-cycle read latency, write-first forbidden (write and read never coincide).

Test Plan:
- Basic frame: W=2, H=1, words 0x44332211, 0x88776655, out_ready=1.
  -> Output order 11,22,55,66,33,44,77,88.
  -> out_eol on 66 and 88; out_eof on 88.
  -> frame_done 1 cycle after the 88 handshake.
- Backpressure: W=4, H=2, out_ready random 50%.
  -> 32 pixels, raster order unchanged.
  -> out_pixel stable whenever out_valid=1 and out_ready=0.
  -> in_ready=0 throughout BOT rows.
- Rejected start: cfg_width=0, H=5.
  -> frame_done next cycle, no out_valid.
- Config error: cfg_width=129.
  -> cfg_err pulse; busy stays 0.
- Start while busy: W=128, H=1 with a second start mid-frame.
  -> Second start ignored; exactly 512 pixels out.
  -> Bottom row equals bytes[23:16]/[31:24] of words 0..127.
- Reset mid-frame: assert HRESET during BOT of a 16x16 frame.
  -> Next cycle: all outputs 0, busy=0.
  -> A fresh 2x1 frame then yields the exact sequence from the basic-frame test.

Source files
------------

// File: rtl/pixel_shuffle_2x_pkg.sv
// Shared types and constants for the 2x depth-to-space output stage.
package pixel_shuffle_2x_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TOP,
    BOT,
    DONE
  } state_e;

  // Byte lanes of one input word: top-left, top-right, bottom-left, bottom-right.
  localparam int TL = 0;
  localparam int TR = 1;
  localparam int BL = 2;
  localparam int BR = 3;

  localparam int DEF_MAX_WIDTH = 128;

  function automatic logic [7:0] lane(input logic [31:0] word, input int idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/pix_line_buf.sv
// Single-port synchronous RAM holding the bottom sub-pixel pair of each low-res column.
module pix_line_buf #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // A write cycle performs no read, so rdata keeps the last read word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/pixel_shuffle_2x.sv
// Depth-to-space (factor 2): 32-bit low-res words in, 8-bit raster of the 2W x 2H image out.
module pixel_shuffle_2x
  import pixel_shuffle_2x_pkg::*;
#(
  parameter int MAX_WIDTH = DEF_MAX_WIDTH,
  parameter int W_SIZE    = 12,
  parameter int W_ADDR_LB = $clog2(MAX_WIDTH)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic [W_SIZE-1:0] cfg_width,
  input  logic [W_SIZE-1:0] cfg_height,
  input  logic [31:0]       in_pixel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_err
);

  state_e            state_q;
  logic [W_SIZE-1:0] w_q, h_q, x_q, y_q, x_d, y_d;
  logic              ph_q;
  logic [7:0]        hold_q, out_pixel_q;
  logic              out_valid_q, out_eol_q, out_eof_q;
  logic              busy_q, frame_done_q, cfg_err_q;
  logic              free, in_hs, last_x, last_y;
  logic [W_ADDR_LB-1:0] lb_addr;
  logic [15:0]       lb_wdata, lb_rdata;

  assign x_d      = x_q + 1'b1;
  assign y_d      = y_q + 1'b1;
  assign free     = !out_valid_q || out_ready;
  assign in_ready = (state_q == TOP) && !ph_q && free;
  assign in_hs    = in_valid && in_ready;
  assign last_x   = (x_q == w_q - 1'b1);
  assign last_y   = (y_q == h_q - 1'b1);
  assign lb_wdata = {lane(in_pixel, BR), lane(in_pixel, BL)};

  // In BOT the next column is fetched one slot early; a stalled slot re-reads x to hold rdata.
  always_comb begin
    lb_addr = '0;
    if (in_hs) begin
      lb_addr = x_q[W_ADDR_LB-1:0];
    end else if (state_q == BOT) begin
      lb_addr = (ph_q || free) ? x_d[W_ADDR_LB-1:0] : x_q[W_ADDR_LB-1:0];
    end
  end

  pix_line_buf #(
    .DEPTH (MAX_WIDTH),
    .AW    (W_ADDR_LB),
    .DW    (16)
  ) u_lb (
    .clk   (HCLK),
    .we    (in_hs),
    .addr  (lb_addr),
    .wdata (lb_wdata),
    .rdata (lb_rdata)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= IDLE;
      w_q          <= '0;
      h_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      ph_q         <= 1'b0;
      out_pixel_q  <= '0;
      out_valid_q  <= 1'b0;
      out_eol_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      if (out_ready) begin
        out_valid_q <= 1'b0;
        out_eol_q   <= 1'b0;
        out_eof_q   <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_width == '0 || cfg_height == '0) begin
              frame_done_q <= 1'b1;
            end else if (cfg_width > W_SIZE'(MAX_WIDTH)) begin
              cfg_err_q <= 1'b1;
            end else begin
              w_q     <= cfg_width;
              h_q     <= cfg_height;
              x_q     <= '0;
              y_q     <= '0;
              ph_q    <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= TOP;
            end
          end
        end
        TOP: begin
          if (!ph_q) begin
            if (in_hs) begin
              out_valid_q <= 1'b1;
              out_pixel_q <= lane(in_pixel, TL);
              out_eol_q   <= 1'b0;
              out_eof_q   <= 1'b0;
              hold_q      <= lane(in_pixel, TR);
              ph_q        <= 1'b1;
            end
          end else if (free) begin
            out_valid_q <= 1'b1;
            out_pixel_q <= hold_q;
            out_eol_q   <= last_x;
            out_eof_q   <= 1'b0;
            ph_q        <= 1'b0;
            if (last_x) begin
              x_q     <= '0;
              state_q <= BOT;
            end else begin
              x_q <= x_d;
            end
          end
        end
        BOT: begin
          if (free) begin
            out_valid_q <= 1'b1;
            if (!ph_q) begin
              out_pixel_q <= lb_rdata[7:0];
              out_eol_q   <= 1'b0;
              out_eof_q   <= 1'b0;
              hold_q      <= lb_rdata[15:8];
              ph_q        <= 1'b1;
            end else begin
              out_pixel_q <= hold_q;
              out_eol_q   <= last_x;
              out_eof_q   <= last_x && last_y;
              ph_q        <= 1'b0;
              if (last_x) begin
                x_q <= '0;
                if (last_y) begin
                  state_q <= DONE;
                end else begin
                  y_q     <= y_d;
                  state_q <= TOP;
                end
              end else begin
                x_q <= x_d;
              end
            end
          end
        end
        DONE: begin
          // Wait for the final pixel to leave before reporting completion.
          if (out_valid_q && out_ready) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_pixel  = out_pixel_q;
  assign out_valid  = out_valid_q;
  assign out_eol    = out_eol_q;
  assign out_eof    = out_eof_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_pixel_shuffle_2x.sv
// Scoreboard bench for pixel_shuffle_2x: expected raster pushed per frame, popped on output handshakes.
module tb_pixel_shuffle_2x;

  logic        HCLK, HRESET, start;
  logic [11:0] cfg_width, cfg_height;
  logic [31:0] in_pixel;
  logic        in_valid, in_ready;
  logic [7:0]  out_pixel;
  logic        out_valid, out_ready, out_eol, out_eof;
  logic        busy, frame_done, cfg_err;

  pixel_shuffle_2x dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_pixel  (out_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_eol    (out_eol),
    .out_eof    (out_eof),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          fed      = 0;
  int          popped   = 0;
  int          eof_cyc  = 0;
  int          base_fed = 0;
  int          base_pop = 0;
  int          cur_w    = 1;
  logic        bp_mode  = 1'b0;
  logic        abort    = 1'b0;
  logic        stall_prev = 1'b0;
  logic [9:0]  held, mon_e;
  logic [9:0]  exp_q[$];
  logic [31:0] mem [256];

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  always @(posedge HCLK) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge HCLK);
      #1 out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: cycle %0d reached, required frame completion", cyc);
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Output-side scoreboard, hold-stability and input-side ordering checks.
  always @(negedge HCLK) begin
    if (!HRESET) begin
      if (stall_prev && out_valid) chk("hold_stable", {22'd0, out_pixel, out_eol, out_eof}, {22'd0, held});
      stall_prev = out_valid && !out_ready;
      held = {out_pixel, out_eol, out_eof};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", {31'd0, out_valid}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pix", {22'd0, out_pixel, out_eol, out_eof}, {22'd0, mon_e});
        end
        popped++;
        if (out_eof) eof_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        if ((fed - base_fed) / cur_w > 0)
          chk("no_input_before_bot_drained", {31'd0, 1'(popped - base_pop >= 4 * cur_w * ((fed - base_fed) / cur_w))}, 1);
        fed++;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic begin_frame(input int w, input int h);
    base_fed = fed;
    base_pop = popped;
    cur_w    = w;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        exp_q.push_back({mem[y*w+x][7:0], 1'b0, 1'b0});
        exp_q.push_back({mem[y*w+x][15:8], 1'(x == w - 1), 1'b0});
      end
      for (int x = 0; x < w; x++) begin
        exp_q.push_back({mem[y*w+x][23:16], 1'b0, 1'b0});
        exp_q.push_back({mem[y*w+x][31:24], 1'(x == w - 1), 1'((x == w - 1) && (y == h - 1))});
      end
    end
  endtask

  task automatic start_frame(input int w, input int h);
    @(posedge HCLK);
    #1;
    cfg_width  = 12'(w);
    cfg_height = 12'(h);
    start      = 1'b1;
    @(posedge HCLK);
    #1 start = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int k = 0; k < n && !abort; k++) begin
      int t = 0;
      in_valid = 1'b1;
      in_pixel = mem[k];
      @(negedge HCLK);
      while (!in_ready && !abort && t < 5000) begin
        @(negedge HCLK);
        t++;
      end
      if (t >= 5000) begin
        chk("in_ready_timeout", {31'd0, in_ready}, 1);
        break;
      end
      @(posedge HCLK);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound, output int at_cyc);
    int t = 0;
    @(negedge HCLK);
    while (!frame_done && t < bound) begin
      @(negedge HCLK);
      t++;
    end
    at_cyc = cyc;
    chk(tag, {31'd0, frame_done}, 1);
  endtask

  task automatic basic_frame(input string tag);
    int c;
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
    begin_frame(2, 1);
    start_frame(2, 1);
    feed(2);
    wait_done({tag, "_done"}, 200, c);
    chk({tag, "_fd_latency"}, 32'(c - eof_cyc), 1);
    chk({tag, "_count"}, 32'(popped - base_pop), 8);
    chk({tag, "_drained"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int c;
    HRESET = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
    in_pixel = '0; in_valid = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("reset_ctrl", {25'd0, in_ready, out_valid, out_eol, out_eof, busy, frame_done, cfg_err}, 0);
    chk("reset_pixel", {24'd0, out_pixel}, 0);
    @(posedge HCLK);
    #1 HRESET = 1'b0;

    basic_frame("basic");

    // Random backpressure, 4x2.
    for (int k = 0; k < 8; k++) mem[k] = $urandom;
    bp_mode = 1'b1;
    begin_frame(4, 2);
    start_frame(4, 2);
    feed(8);
    wait_done("bp_done", 3000, c);
    bp_mode = 1'b0;
    chk("bp_count", 32'(popped - base_pop), 32);
    chk("bp_drained", 32'(exp_q.size()), 0);

    // Zero-width start completes at once with no output.
    start_frame(0, 5);
    @(negedge HCLK);
    chk("zero_frame_done", {31'd0, frame_done}, 1);
    chk("zero_busy", {31'd0, busy}, 0);
    @(negedge HCLK);
    chk("zero_done_pulse", {31'd0, frame_done}, 0);
    repeat (4) @(negedge HCLK);
    chk("zero_no_output", {31'd0, out_valid}, 0);

    // Oversized width is rejected.
    start_frame(129, 1);
    @(negedge HCLK);
    chk("cfg_err_pulse", {30'd0, cfg_err, busy}, 32'b10);
    @(negedge HCLK);
    chk("cfg_err_clear", {30'd0, cfg_err, busy}, 0);

    // Full-width frame with a second start while busy.
    for (int k = 0; k < 128; k++) mem[k] = $urandom;
    begin_frame(128, 1);
    start_frame(128, 1);
    fork
      feed(128);
      begin
        repeat (60) @(posedge HCLK);
        #1;
        cfg_width = 12'd2; cfg_height = 12'd1; start = 1'b1;
        @(posedge HCLK);
        #1 start = 1'b0;
      end
    join
    wait_done("wide_done", 3000, c);
    chk("wide_count", 32'(popped - base_pop), 512);
    chk("wide_drained", 32'(exp_q.size()), 0);
    repeat (10) @(negedge HCLK);
    chk("wide_no_second_frame", {31'd0, busy}, 0);
    chk("wide_count_after", 32'(popped - base_pop), 512);

    // Reset during the first bottom row of a 16x16 frame.
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    begin_frame(16, 16);
    start_frame(16, 16);
    fork
      feed(256);
      begin
        int t = 0;
        while (fed - base_fed < 16 && t < 2000) begin
          @(negedge HCLK);
          t++;
        end
        chk("mid_reset_reach_bot", 32'(fed - base_fed), 16);
        repeat (4) @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        abort  = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        chk("mid_reset_ctrl", {25'd0, in_ready, out_valid, out_eol, out_eof, busy, frame_done, cfg_err}, 0);
        chk("mid_reset_pixel", {24'd0, out_pixel}, 0);
      end
    join
    @(posedge HCLK);
    #1;
    exp_q.delete();
    HRESET = 1'b0;
    abort  = 1'b0;
    @(negedge HCLK);
    chk("post_reset_idle", {30'd0, busy, frame_done}, 0);

    basic_frame("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
